// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out word reader.
//
// A WIDTH-bit word is accepted over a valid/ready load handshake. It is
// captured into an internal shift register and then drained one bit per
// serial handshake (o_svalid/i_sready). o_last flags the final bit of each
// frame. A new word may load on the same edge as the final bit transfers,
// so frames can follow each other back to back.
//
// Parameters
//   WIDTH      data word width, 2..32
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//
// Optional feature (macro PISO_PARITY_EN)
//   When defined, an even-parity bit (XOR of the loaded word) is appended
//   after the data bits, so a frame is WIDTH+1 bits long.
//
// Ports
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_valid    parallel word offered on i_d
//   o_ready    a word can be accepted this cycle (combinational on i_sready)
//   i_d        parallel word
//   o_sdata    current serial bit
//   o_svalid   o_sdata is valid
//   i_sready   consumer accepts o_sdata this cycle
//   o_last     current serial bit is the final bit of the frame
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_sdata,
  output logic             o_svalid,
  input  logic             i_sready,
  output logic             o_last
);

`ifdef PISO_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW = $clog2(F + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  logic [F-1:0]   r_sreg;
  logic [CW-1:0]  r_cnt;

  logic [F-1:0]   w_load_word;
  logic           w_load;
  logic           w_xfer;

  // The parity bit is placed in the register at load time on the side that
  // drains last, so it falls out of the normal shift after the data bits.
  always_comb begin
    w_load_word = '0;
`ifdef PISO_PARITY_EN
    if (MSB_FIRST != 0) w_load_word = {i_d, ^i_d};
    else                w_load_word = {^i_d, i_d};
`else
    w_load_word = i_d;
`endif
  end

  assign o_svalid = (r_state == SHIFT);
  assign o_last   = (r_state == SHIFT) && (r_cnt == CW'(F - 1));
  assign o_sdata  = (MSB_FIRST != 0) ? r_sreg[F-1] : r_sreg[0];
  assign o_ready  = (r_state == IDLE) || (o_last && i_sready);

  assign w_load = i_valid && o_ready;
  assign w_xfer = o_svalid && i_sready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      // A load can coincide with a transfer only on the final bit; the load
      // wins so the next frame starts without a bubble.
      if (w_load) begin
        r_sreg  <= w_load_word;
        r_cnt   <= '0;
        r_state <= SHIFT;
      end else if (w_xfer) begin
        if (MSB_FIRST != 0) r_sreg <= {r_sreg[F-2:0], 1'b0};
        else                r_sreg <= {1'b0, r_sreg[F-1:1]};
        r_cnt <= r_cnt + 1'b1;
        if (o_last) r_state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic         sready = 1'b0;
  logic [W-1:0] d = '0;

  logic rdy_m, sd_m, sv_m, last_m;
  logic rdy_l, sd_l, sv_l, last_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(rdy_m),
    .i_d(d), .o_sdata(sd_m), .o_svalid(sv_m), .i_sready(sready), .o_last(last_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(rdy_l),
    .i_d(d), .o_sdata(sd_l), .o_svalid(sv_l), .i_sready(sready), .o_last(last_l)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         sr;
    logic         rdy;
    logic         sv;
    logic         bm;
    logic         bl;
    logic         last;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the remaining bits of the current frame, in send order.
  logic qm[$];
  logic ql[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are looked at 1 time unit later.
  task automatic drive(input logic v, input logic [W-1:0] dd, input logic sr);
    @(negedge clk);
    valid  = v;
    d      = dd;
    sready = sr;
    #1;
  endtask

  function automatic void add(input logic v, input logic [W-1:0] dd, input logic sr,
                              input logic rdy, input logic sv, input logic bm,
                              input logic bl, input logic last);
    vec_t e;
    e.v = v; e.d = dd; e.sr = sr; e.rdy = rdy; e.sv = sv;
    e.bm = bm; e.bl = bl; e.last = last;
    tbl.push_back(e);
  endfunction

  function automatic void push_frame(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) qm.push_back(w[i]);
    for (int i = 0; i < W; i++)      ql.push_back(w[i]);
`ifdef PISO_PARITY_EN
    qm.push_back(^w);
    ql.push_back(^w);
`endif
  endfunction

  // Compare both DUTs against the model for the current cycle, then advance
  // the model by the handshakes that will happen at the coming rising edge.
  task automatic model_check(input string tag);
    logic exp_rdy;
    exp_rdy = (qm.size() == 0) || (qm.size() == 1 && sready);
    chk({tag, "_m_svalid"}, sv_m, qm.size() != 0);
    chk({tag, "_l_svalid"}, sv_l, ql.size() != 0);
    chk({tag, "_m_last"}, last_m, qm.size() == 1);
    chk({tag, "_l_last"}, last_l, ql.size() == 1);
    chk({tag, "_m_ready"}, rdy_m, exp_rdy);
    chk({tag, "_l_ready"}, rdy_l, exp_rdy);
    if (qm.size() != 0) chk({tag, "_m_sdata"}, sd_m, qm[0]);
    if (ql.size() != 0) chk({tag, "_l_sdata"}, sd_l, ql[0]);
    if (qm.size() != 0 && sready) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (valid && exp_rdy) push_frame(d);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_ready"}, rdy_m, 1'b1);
    chk({tag, "_l_ready"}, rdy_l, 1'b1);
    chk({tag, "_m_svalid"}, sv_m, 1'b0);
    chk({tag, "_l_svalid"}, sv_l, 1'b0);
    chk({tag, "_m_sdata"}, sd_m, 1'b0);
    chk({tag, "_l_sdata"}, sd_l, 1'b0);
    chk({tag, "_m_last"}, last_m, 1'b0);
    chk({tag, "_l_last"}, last_l, 1'b0);
  endtask

`ifdef PISO_PARITY_EN
  // em/el hold the expected serial stream, first bit at index 0.
  task automatic run_frame(input string tag, input logic [W-1:0] w,
                           input logic [7:0] em, input logic [7:0] el);
    drive(1'b1, w, 1'b1);
    chk({tag, "_load_ready"}, rdy_m, 1'b1);
    for (int k = 0; k < F; k++) begin
      drive(1'b0, '0, 1'b1);
      chk($sformatf("%s_b%0d_m_sdata", tag, k), sd_m, em[k]);
      chk($sformatf("%s_b%0d_l_sdata", tag, k), sd_l, el[k]);
      chk($sformatf("%s_b%0d_last", tag, k), last_m, k == F - 1);
    end
  endtask
`endif

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

`ifndef PISO_PARITY_EN
    //    v  d        sr  rdy sv bm bl last
    // Basic frame 1011: msb 1,0,1,1 / lsb 1,1,0,1
    add(1, 4'b1011, 1,  1, 0, 0, 0, 0);
    add(0, 4'b0000, 1,  0, 1, 1, 1, 0);
    add(0, 4'b0000, 1,  0, 1, 0, 1, 0);
    add(0, 4'b0000, 1,  0, 1, 1, 0, 0);
    add(0, 4'b0000, 1,  1, 1, 1, 1, 1);
    add(0, 4'b0000, 1,  1, 0, 0, 0, 0);
    // Stalls on 0110, i_sready 1,0,0,1,1,0,1; valid during stall is ignored
    add(1, 4'b0110, 0,  1, 0, 0, 0, 0);
    add(0, 4'b0000, 1,  0, 1, 0, 0, 0);
    add(1, 4'b1111, 0,  0, 1, 1, 1, 0);
    add(0, 4'b0000, 0,  0, 1, 1, 1, 0);
    add(0, 4'b0000, 1,  0, 1, 1, 1, 0);
    add(0, 4'b0000, 1,  0, 1, 1, 1, 0);
    add(0, 4'b0000, 0,  0, 1, 0, 0, 1);
    add(0, 4'b0000, 1,  1, 1, 0, 0, 1);
    add(0, 4'b0000, 1,  1, 0, 0, 0, 0);
    // Back-to-back A then 5: msb 1010 0101 / lsb 0101 1010
    add(1, 4'hA,    1,  1, 0, 0, 0, 0);
    add(1, 4'h5,    1,  0, 1, 1, 0, 0);
    add(1, 4'h5,    1,  0, 1, 0, 1, 0);
    add(1, 4'h5,    1,  0, 1, 1, 0, 0);
    add(1, 4'h5,    1,  1, 1, 0, 1, 1);
    add(0, 4'h0,    1,  0, 1, 0, 1, 0);
    add(0, 4'h0,    1,  0, 1, 1, 0, 0);
    add(0, 4'h0,    1,  0, 1, 0, 1, 0);
    add(0, 4'h0,    1,  1, 1, 1, 0, 1);
    add(0, 4'h0,    1,  1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].sr);
      chk($sformatf("row%0d_m_ready", i), rdy_m, tbl[i].rdy);
      chk($sformatf("row%0d_l_ready", i), rdy_l, tbl[i].rdy);
      chk($sformatf("row%0d_m_svalid", i), sv_m, tbl[i].sv);
      chk($sformatf("row%0d_l_svalid", i), sv_l, tbl[i].sv);
      chk($sformatf("row%0d_m_last", i), last_m, tbl[i].last);
      chk($sformatf("row%0d_l_last", i), last_l, tbl[i].last);
      if (tbl[i].sv) begin
        chk($sformatf("row%0d_m_sdata", i), sd_m, tbl[i].bm);
        chk($sformatf("row%0d_l_sdata", i), sd_l, tbl[i].bl);
      end
    end
`else
    // 1011 -> msb 1,0,1,1,1 / lsb 1,1,0,1,1 ; 0110 -> parity bit 0
    run_frame("par1011", 4'b1011, 8'b0001_1101, 8'b0001_1011);
    run_frame("par0110", 4'b0110, 8'b0000_0110, 8'b0000_0110);
    drive(1'b0, '0, 1'b1);
    chk("par_idle_ready", rdy_m, 1'b1);
`endif

    // Reset in the middle of a frame of 4'hF, after two bits transferred
    drive(1'b1, 4'hF, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("midframe_svalid", sv_m, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_m_ready", rdy_m, 1'b1);
    chk("release_l_ready", rdy_l, 1'b1);
    qm.delete();
    ql.delete();
    drive(1'b1, 4'h3, 1'b1);
    model_check("after_reset_load");
    for (int k = 0; k < F + 1; k++) begin
      drive(1'b0, '0, 1'b1);
      model_check($sformatf("after_reset_b%0d", k));
    end

    // Randomized traffic against the frame-queue model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6);
      model_check($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out word reader: accepts a WIDTH-bit word over a valid/ready load handshake, holds it in an internal shift register, and drains it one bit per serial handshake. It is the read-side counterpart to the team's enabled capture registers. It sits between a parallel datapath register and a bit-serial consumer, such as a link transmitter or a debug shift chain.

## Interface
- WIDTH, default 4: data word width in bits; legal range 2-32.
- MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- i_clk  input  1  clock; all state changes on its rising edge.
- i_reset_n  input  1  reset, asynchronous and active-low; resets all state immediately on assertion.
- i_valid  input  1  a parallel word is offered on i_d.
- o_ready  output  1  the serializer can accept a word this cycle.
- i_d  input  WIDTH  parallel word.
- o_sdata  output  1  current serial bit.
- o_svalid  output  1  o_sdata is valid.
- i_sready  input  1  the consumer accepts o_sdata this cycle.
- o_last  output  1  the current serial bit is the final bit of the frame.

## Operation
- **State machine:** two states.
  - IDLE: o_svalid=0. o_ready=1.
  - SHIFT: o_svalid=1.
- **Load:** a load occurs when i_valid&&o_ready is high at a clock edge.
  - The shift register captures i_d.
  - The bit counter is cleared to 0.
  - The state goes to SHIFT.
- **Serial transfer:** a serial transfer occurs when o_svalid&&i_sready is high at a clock edge.
  - The shift register advances one position.
  - The counter increments.
- **Hold:** while i_sready=0, o_sdata and o_last hold their values.
- **Bit order:** MSB_FIRST=1 presents i_d[WIDTH-1] down to i_d[0]. MSB_FIRST=0 presents i_d[0] up to i_d[WIDTH-1].
- **Frame length:** F = WIDTH (or WIDTH+1, see Configuration).
- **o_last:** high when the state is SHIFT and counter == F-1.
- **End of frame:** a serial transfer with o_last=1 ends the frame.
  - If i_valid=1 in that same cycle, the new word loads and the state stays SHIFT, giving back-to-back frames with no bubble.
  - Otherwise the state returns to IDLE.
- **o_ready:** o_ready = (state==IDLE) || (o_last && i_sready).
  - This is a combinational path from i_sready to o_ready.
  - A consumer must not make i_sready depend on o_ready.
- **Ignored input:** i_valid is ignored when o_ready=0. i_d is sampled only at a load.
- **Counter width:** $clog2(F+1) bits. It never wraps within a frame and clears on every load.
- **Reset:** asynchronous assertion mid-frame discards the word. All outputs go to reset values immediately, with no partial frame completion.

## Timing
- **Reset values:** state IDLE, o_ready=1, o_svalid=0, o_sdata=0, o_last=0. Shift register and counter are 0.
- **Load latency:** a load at edge N presents the first bit with o_svalid=1 during cycle N+1.
- **Throughput:** with i_sready held at 1, one bit per cycle. A frame occupies F cycles. Continuous i_valid gives 100% serial-line utilisation.
- **Stall:** each bit remains stable for as long as i_sready=0, with no upper bound.
- **Reset release:** on deassertion of i_reset_n, the first load is accepted at the first rising edge with i_valid=1.

## Configuration
- **PISO_PARITY_EN defined:**
  - A single even-parity bit (XOR of all WIDTH bits of the loaded word) is appended after the data bits. F = WIDTH+1.
  - Parity is computed at load time and stored; it is not recomputed from shifted data.
  - o_last marks the parity bit.
- **PISO_PARITY_EN undefined:** F = WIDTH. No parity logic or storage is present.

## Test plan
- **Basic MSB-first frame:** WIDTH=4, MSB_FIRST=1, load 4'b1011, i_sready=1.
  - o_sdata is 1,0,1,1 on cycles N+1..N+4.
  - o_last is high only on N+4.
  - IDLE with o_ready=1 at N+5.
- **LSB-first frame:** MSB_FIRST=0, load 4'b1011 -> o_sdata is 1,1,0,1.
- **Stalls:** load 4'b0110, then i_sready toggles 1,0,0,1,1,0,1.
  - Exactly 4 accepted bits: 0,1,1,0.
  - o_sdata is stable across each stall cycle.
  - o_ready stays 0 until the last accepted bit.
- **Back-to-back loads:** load 4'hA, with i_valid held high and 4'h5 waiting.
  - 4'h5 loads on the cycle 4'hA's last bit transfers.
  - Serial stream is 1,0,1,0,0,1,0,1 with o_svalid continuously 1.
- **Reset mid-frame:** load 4'hF, assert i_reset_n=0 after 2 bits.
  - o_svalid=0, o_sdata=0 and o_last=0 immediately.
  - o_ready=1 after release.
  - The next load of 4'h3 serializes fully and correctly.
- **Parity (PISO_PARITY_EN):** load 4'b1011 -> 1,0,1,1,1 with o_last on the 5th bit. Load 4'b0110 -> parity bit 0.
